// File: rtl/pe_ctrl_pkg.sv
package pe_ctrl_pkg;

  localparam int unsigned NUM_SEL = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned WGT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/pe_weight_loader.sv
module pe_weight_loader
  import pe_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              active,
  input  logic              w_valid,
  input  logic [WGT_W-1:0]  w_data,
  output logic              w_ready,
  output logic [WGT_W-1:0]  pe_weight_load,
  output logic [NUM_PE-1:0] pe_weight_load_en,
  output logic [SEL_W-1:0]  pe_weight_load_sel,
  output logic              last_beat
);

  localparam int unsigned       NUM_BEATS = NUM_SEL * NUM_PE;
  localparam int unsigned       IDX_W     = $clog2(NUM_BEATS);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_BEATS - 1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] pe_idx;
  logic             beat;

  // PE-major beat order: upper index bits pick the PE, lower bits the slot
  always_comb begin
    w_ready            = active;
    beat               = active & w_valid;
    last_beat          = beat & (idx_q == LAST_IDX);
    pe_weight_load     = active ? w_data : '0;
    pe_weight_load_sel = active ? idx_q[SEL_W-1:0] : '0;
    pe_idx             = idx_q >> SEL_W;
    pe_weight_load_en  = '0;
    for (int unsigned p = 0; p < NUM_PE; p++) begin
      if (beat && (pe_idx == IDX_W'(p))) begin
        pe_weight_load_en[p] = 1'b1;
      end
    end
    idx_d = idx_q;
    if (clear) begin
      idx_d = '0;
    end else if (beat) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/pe_row_ctrl.sv
module pe_row_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PE = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_npix,
  output logic              busy,
  output logic              done,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [7:0]        w_data,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic [7:0]        x_data,
  output logic [7:0]        pe_weight_load,
  output logic [NUM_PE-1:0] pe_weight_load_en,
  output logic [1:0]        pe_weight_load_sel,
  output logic [7:0]        pe_imap_in,
  output logic              pipe_en,
  output logic              pe_en,
  output logic [1:0]        weight_sel,
  output logic              prod_valid,
  output logic [1:0]        prod_sel,
  output logic              prod_last
);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_SEL - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] npix_q, npix_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic             have_q, have_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             prod_valid_q, prod_valid_d;
  logic [SEL_W-1:0] prod_sel_q, prod_sel_d;
  logic             prod_last_q, prod_last_d;

  logic             load_clear;
  logic             load_active;
  logic             last_beat;
  logic             x_acc;
  logic             last_pe;

  pe_weight_loader #(
    .NUM_PE (NUM_PE)
  ) u_loader (
    .clk                (clk),
    .rst_n              (rst_n),
    .clear              (load_clear),
    .active             (load_active),
    .w_valid            (w_valid),
    .w_data             (w_data),
    .w_ready            (w_ready),
    .pe_weight_load     (pe_weight_load),
    .pe_weight_load_en  (pe_weight_load_en),
    .pe_weight_load_sel (pe_weight_load_sel),
    .last_beat          (last_beat)
  );

  always_comb begin
    load_clear  = (state_q == ST_IDLE) & start;
    load_active = (state_q == ST_LOAD);
    busy        = (state_q != ST_IDLE);
    done        = (state_q == ST_DONE);
    prod_valid  = prod_valid_q;
    prod_sel    = prod_sel_q;
    prod_last   = prod_last_q;
  end

  // A pixel accepted in the sel==3 cycle overrides the have-clear and sel wrap,
  // so the resident pixel is consumed on the same edge the new one enters.
  always_comb begin
    state_d    = state_q;
    npix_d     = npix_q;
    pix_cnt_d  = pix_cnt_q;
    have_d     = have_q;
    sel_d      = sel_q;
    x_ready    = 1'b0;
    x_acc      = 1'b0;
    pipe_en    = 1'b0;
    pe_imap_in = '0;
    pe_en      = 1'b0;
    weight_sel = '0;
    last_pe    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LOAD;
          npix_d    = cfg_npix;
          pix_cnt_d = '0;
          have_d    = 1'b0;
          sel_d     = '0;
        end
      end
      ST_LOAD: begin
        if (last_beat) begin
          state_d = (npix_q != '0) ? ST_COMPUTE : ST_DONE;
        end
      end
      ST_COMPUTE: begin
        x_ready = (pix_cnt_q < npix_q) & (!have_q | (sel_q == SEL_LAST));
        x_acc   = x_ready & x_valid;
        if (have_q) begin
          pe_en      = 1'b1;
          weight_sel = sel_q;
          sel_d      = sel_q + SEL_W'(1);
          if (sel_q == SEL_LAST) begin
            have_d = 1'b0;
            if (pix_cnt_q == npix_q) begin
              last_pe = 1'b1;
              state_d = ST_DONE;
            end
          end
        end
        if (x_acc) begin
          pipe_en    = 1'b1;
          pe_imap_in = x_data;
          have_d     = 1'b1;
          sel_d      = '0;
          pix_cnt_d  = pix_cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    prod_valid_d = pe_en;
    prod_sel_d   = weight_sel;
    prod_last_d  = last_pe;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      npix_q       <= '0;
      pix_cnt_q    <= '0;
      have_q       <= 1'b0;
      sel_q        <= '0;
      prod_valid_q <= 1'b0;
      prod_sel_q   <= '0;
      prod_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      npix_q       <= npix_d;
      pix_cnt_q    <= pix_cnt_d;
      have_q       <= have_d;
      sel_q        <= sel_d;
      prod_valid_q <= prod_valid_d;
      prod_sel_q   <= prod_sel_d;
      prod_last_q  <= prod_last_d;
    end
  end

endmodule

// File: tb/tb_pe_row_ctrl.sv
module tb_pe_row_ctrl;

  localparam int unsigned NUM_PE = 2;
  localparam int unsigned CNT_W  = 16;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [CNT_W-1:0]  cfg_npix;
  logic              busy;
  logic              done;
  logic              w_valid;
  logic              w_ready;
  logic [7:0]        w_data;
  logic              x_valid;
  logic              x_ready;
  logic [7:0]        x_data;
  logic [7:0]        pe_weight_load;
  logic [NUM_PE-1:0] pe_weight_load_en;
  logic [1:0]        pe_weight_load_sel;
  logic [7:0]        pe_imap_in;
  logic              pipe_en;
  logic              pe_en;
  logic [1:0]        weight_sel;
  logic              prod_valid;
  logic [1:0]        prod_sel;
  logic              prod_last;

  pe_row_ctrl #(
    .NUM_PE (NUM_PE),
    .CNT_W  (CNT_W)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .cfg_npix           (cfg_npix),
    .busy               (busy),
    .done               (done),
    .w_valid            (w_valid),
    .w_ready            (w_ready),
    .w_data             (w_data),
    .x_valid            (x_valid),
    .x_ready            (x_ready),
    .x_data             (x_data),
    .pe_weight_load     (pe_weight_load),
    .pe_weight_load_en  (pe_weight_load_en),
    .pe_weight_load_sel (pe_weight_load_sel),
    .pe_imap_in         (pe_imap_in),
    .pipe_en            (pipe_en),
    .pe_en              (pe_en),
    .weight_sel         (weight_sel),
    .prod_valid         (prod_valid),
    .prod_sel           (prod_sel),
    .prod_last          (prod_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the PE row: weight buffers, PE0 imap stage and product register
  logic signed [7:0]  wm [NUM_PE][4];
  logic signed [7:0]  chain0;
  logic signed [15:0] prod0;

  always @(posedge clk) begin
    for (int unsigned p = 0; p < NUM_PE; p++) begin
      if (pe_weight_load_en[p]) wm[p][pe_weight_load_sel] <= pe_weight_load;
    end
    if (pipe_en) chain0 <= pe_imap_in;
    if (pe_en)   prod0  <= chain0 * wm[0][weight_sel];
  end

  typedef struct {
    int sel;
    int last;
    int val;
  } exp_t;

  typedef struct packed {
    int unsigned      npix;
    logic [3:0][7:0]  pix;
    int unsigned      gap;
    int               wbase;
    int unsigned      glitch;
    int unsigned      exp_pe;
    int unsigned      exp_pipe;
    int unsigned      exp_gap;
    int unsigned      exp_last;
  } job_t;

  exp_t sb[$];
  job_t jobs [4];

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  int wexp0 [4];
  int cur_last, cur_gap;
  int pe_cnt, pipe_cnt, pv_cnt, done_cnt, last_cnt;
  int first_pe, last_pe, done_cyc, last_cyc, last_beat_cyc, prev_pipe;
  logic w_acc, x_acc;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs();
    return int'({busy, done, w_ready, x_ready, pipe_en, pe_en, prod_valid, prod_last,
                 prod_sel, weight_sel, pe_weight_load_sel, pe_weight_load_en,
                 pe_weight_load, pe_imap_in});
  endfunction

  function automatic job_t mk(input int unsigned npix, input logic [31:0] pix,
                              input int unsigned gap, input int wbase, input int unsigned glitch,
                              input int unsigned ep, input int unsigned epp,
                              input int unsigned eg, input int unsigned el);
    job_t j;
    j.npix = npix; j.pix = pix; j.gap = gap; j.wbase = wbase; j.glitch = glitch;
    j.exp_pe = ep; j.exp_pipe = epp; j.exp_gap = eg; j.exp_last = el;
    return j;
  endfunction

  // One clock: observe/score at the falling edge, return just after the rising edge
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    cyc_n++;
    w_acc = w_valid && w_ready;
    x_acc = x_valid && x_ready;
    if (prod_valid) begin
      pv_cnt++;
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("prod_sel", int'(prod_sel), e.sel);
        chk("prod_last", int'(prod_last), e.last);
        chk("prod_val", int'(prod0), e.val);
      end
    end
    if (pe_en) begin
      pe_cnt++;
      if (first_pe < 0) first_pe = cyc_n;
      last_pe = cyc_n;
    end
    if (pipe_en) begin
      if (prev_pipe >= 0) chk("pipe_spacing", cyc_n - prev_pipe, (pipe_cnt == 1) ? 4 + cur_gap : 4);
      prev_pipe = cyc_n;
      pipe_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc_n;
    end
    if (prod_last) begin
      last_cnt++;
      last_cyc = cyc_n;
    end
    if (w_acc) last_beat_cyc = cyc_n;
    if (x_acc) begin
      for (int unsigned s = 0; s < 4; s++) begin
        e.sel  = int'(s);
        e.last = (cur_last != 0 && s == 3) ? 1 : 0;
        e.val  = int'($signed(x_data)) * wexp0[s];
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input job_t j);
    int n;
    pe_cnt = 0; pipe_cnt = 0; pv_cnt = 0; done_cnt = 0; last_cnt = 0;
    first_pe = -1; last_pe = -1; done_cyc = -1; last_cyc = -1; last_beat_cyc = -1;
    prev_pipe = -1; cur_gap = int'(j.gap); cur_last = 0;
    sb.delete();
    for (int unsigned s = 0; s < 4; s++) wexp0[s] = j.wbase + int'(s);

    cfg_npix = CNT_W'(j.npix);
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);

    for (int unsigned k = 0; k < 4 * NUM_PE; k++) begin
      w_valid = 1'b1;
      w_data  = 8'(j.wbase + int'(k));
      if (k == 0) begin
        #1;
        chk("first_beat_en", int'(pe_weight_load_en), 1);
        chk("first_beat_sel", int'(pe_weight_load_sel), 0);
      end
      n = 0;
      do begin
        cycle();
        n++;
      end while (!w_acc && n < 200);
      if (!w_acc) begin
        chk("timeout_w", 0, 1);
        w_valid = 1'b0;
        return;
      end
    end
    w_valid = 1'b0;
    w_data  = '0;
    chk("w_ready_drop", int'(w_ready), 0);
    for (int unsigned p = 0; p < NUM_PE; p++) begin
      for (int unsigned s = 0; s < 4; s++) begin
        chk("weight", int'(wm[p][s]), j.wbase + int'(4 * p + s));
      end
    end

    for (int unsigned i = 0; i < j.npix; i++) begin
      cur_last = (i == j.npix - 1) ? 1 : 0;
      x_valid  = 1'b1;
      x_data   = j.pix[i];
      if (j.glitch != 0 && i == 1) begin
        start    = 1'b1;
        cfg_npix = CNT_W'(9);
      end
      n = 0;
      do begin
        cycle();
        start = 1'b0;
        n++;
      end while (!x_acc && n < 200);
      x_valid = 1'b0;
      if (!x_acc) begin
        chk("timeout_x", 0, 1);
        return;
      end
      if (i == 0 && j.gap > 0) repeat (3 + j.gap) cycle();
    end

    n = 0;
    while (done_cnt == 0 && n < 200) begin
      cycle();
      n++;
    end
    if (done_cnt == 0) chk("timeout_done", 0, 1);
    chk("busy_clear", int'(busy), 0);
    repeat (3) cycle();

    chk("pe_cnt", pe_cnt, int'(j.exp_pe));
    chk("pipe_cnt", pipe_cnt, int'(j.exp_pipe));
    chk("prod_valid_cnt", pv_cnt, int'(j.exp_pe));
    chk("done_cnt", done_cnt, 1);
    chk("prod_last_cnt", last_cnt, int'(j.exp_last));
    chk("sb_empty", sb.size(), 0);
    if (j.npix > 0) begin
      chk("pe_gap", (last_pe - first_pe + 1) - pe_cnt, int'(j.exp_gap));
      chk("done_lat", done_cyc - last_pe, 1);
      chk("prod_last_lat", last_cyc - last_pe, 1);
    end else begin
      chk("done_after_beat", done_cyc - last_beat_cyc, 1);
    end
  endtask

  initial begin
    int n;
    //              npix pixels(3..0)                  gap wbase glitch pe pipe gap last
    jobs[0] = mk(3, {8'h00, 8'd30, 8'd20, 8'd10},      0,  1,   1,    12, 3,   0,  1);
    jobs[1] = mk(2, {8'h00, 8'h00, 8'd5,  8'hF9},      5,  -4,  0,    8,  2,   5,  1);
    jobs[2] = mk(0, {8'h00, 8'h00, 8'h00, 8'h00},      0,  20,  0,    0,  0,   0,  0);
    jobs[3] = mk(1, {8'h00, 8'h00, 8'h00, 8'h7F},      0,  100, 0,    4,  1,   0,  1);

    rst_n = 1'b0; start = 1'b0; cfg_npix = '0;
    w_valid = 1'b0; w_data = '0; x_valid = 1'b0; x_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", outs(), 0);
    rst_n = 1'b1;
    cycle();
    chk("idle_busy", int'(busy), 0);

    for (int unsigned t = 0; t < 3; t++) run_job(jobs[t]);

    // Abort a load after three beats
    cfg_npix = CNT_W'(1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      w_valid = 1'b1;
      w_data  = 8'(50 + int'(k));
      n = 0;
      do begin
        cycle();
        n++;
      end while (!w_acc && n < 200);
      if (!w_acc) chk("timeout_abort_w", 0, 1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_outs", outs(), 0);
    @(posedge clk);
    #1;
    chk("abort_outs_held", outs(), 0);
    rst_n   = 1'b1;
    w_valid = 1'b0;
    chk("abort_w00", int'(wm[0][0]), 50);
    chk("abort_w02", int'(wm[0][2]), 52);
    chk("abort_w03_kept", int'(wm[0][3]), 23);
    chk("abort_w10_kept", int'(wm[1][0]), 24);
    cycle();
    chk("abort_no_done", done_cnt, 1);

    run_job(jobs[3]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/pe_row_ctrl.md
# pe_row_ctrl

Sequencer for one row of `NUM_PE` chained `basic_pe` multiplier cells. It streams 4·`NUM_PE` weights into the PE weight buffers over a valid/ready port. It then feeds an imap pixel stream through the PE shift chain, reusing each pixel across all four weight slots. It sits between the buffer/DMA front end and the PE row, and tags every product cycle for the downstream accumulator.

## Interface
Parameters:
- `NUM_PE`, default 8: number of PEs in the row (≥1).
- `CNT_W`, default 16: width of the pixel count.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: begin a job; sampled only in IDLE.
- `cfg_npix` in `CNT_W`: pixels in the job; latched when `start` is accepted.
- `busy` out 1: job in progress.
- `done` out 1: single-cycle job-complete pulse.
- `w_valid` / `w_ready` in/out 1: weight stream handshake.
- `w_data` in 8: signed weight.
- `x_valid` / `x_ready` in/out 1: imap stream handshake.
- `x_data` in 8: signed pixel.
- `pe_weight_load` out 8: shared weight bus to all PEs.
- `pe_weight_load_en` out `NUM_PE`: one-hot per-PE load enable.
- `pe_weight_load_sel` out 2: weight slot being written.
- `pe_imap_in` out 8: pixel into PE[0] of the chain.
- `pipe_en` out 1: shift enable for the imap chain.
- `pe_en` out 1: multiplier enable.
- `weight_sel` out 2: weight slot used this cycle.
- `prod_valid` out 1: PE products are valid this cycle.
- `prod_sel` out 2: slot that produced the current products.
- `prod_last` out 1: final product cycle of the job.

## Operation
- States: IDLE, LOAD, COMPUTE, DONE. `busy` = (state ≠ IDLE). `done` = (state == DONE).
- IDLE → LOAD on `start`. `start` is ignored in all other states.
- LOAD:
  - `w_ready` = 1. Each accepted beat k (0…4·NUM_PE−1) goes to PE k/4, slot k%4, i.e. PE-major order.
  - `pe_weight_load` = `w_data`, `pe_weight_load_sel` = k%4, `pe_weight_load_en` = onehot(k/4) & (`w_valid`&`w_ready`). These are combinational, so the PE captures the weight on the same edge as the handshake.
  - After the last beat: go to COMPUTE if latched npix > 0, else go to DONE.
- COMPUTE:
  - Internal flag `have` (a pixel is resident in the PE chain) and 2-bit `sel`.
  - `x_ready` = (pix_cnt < npix) & (!`have` | `sel`==3).
  - On accept: `pipe_en` = 1, `pe_imap_in` = `x_data`; `have` is set, `sel` goes to 0, and `pix_cnt` increments.
  - When `have`=1: `pe_en` = 1, `weight_sel` = `sel`, and `sel` increments. At `sel`==3 with no accept in the same cycle, `have` clears.
  - Accepting a new pixel in the `sel`==3 cycle is legal. The PE multiplies the old pixel on that edge, so back-to-back pixels sustain 1 pixel per 4 cycles.
  - Go to DONE after the `sel`==3 cycle in which pix_cnt == npix.
- DONE lasts one cycle, then → IDLE.
- Outside LOAD, all load enables are 0. Outside COMPUTE, `pipe_en`, `pe_en` and `x_ready` are 0; `w_ready` is 0 outside LOAD.
- Arithmetic: pix_cnt is `CNT_W` bits and never wraps, since npix ≤ 2^CNT_W−1. The weight index counter is ceil(log2(4·NUM_PE)) bits and clears on entering LOAD.

## Timing
- Reset values: state IDLE, all counters 0, `have` 0, and every output 0 (`busy`, `done`, the ready signals, enables, sels, `prod_*`).
- Reset asserted mid-job aborts the job immediately, with no `done`. Weights already written to the PEs stay as they are.
- `start` in cycle S → LOAD and `busy`=1 from S+1.
- `prod_valid`, `prod_sel` and `prod_last` are registered copies of `pe_en`, `weight_sel` and (last pixel & `sel`==3 & `pe_en`). They align with the PE product register, one cycle after `pe_en`.
- Final `pe_en` in cycle T → `prod_last`=1 and `done`=1 in T+1, and `busy`=0 from T+2.
- With npix = 0, the last weight beat in cycle L → `done` in L+1.
- Stalls (`w_valid`=0 or `x_valid`=0) only insert idle cycles. `pe_en` never asserts while `have`=0.

## Structure
- Package `pe_ctrl_pkg` holds the state enum (IDLE/LOAD/COMPUTE/DONE), `NUM_SEL`=4, `SEL_W`=2, and the weight width of 8.
- One sub-module is natural: `pe_weight_loader`. It contains the LOAD beat counter and the one-hot/slot decode, and outputs a `last_beat` flag. The FSM, compute counters and product tagging stay in the top level.

## Test plan
- NUM_PE=2, weights 1…8 streamed with no stalls → PE0 slots 0–3 hold 1,2,3,4 and PE1 slots hold 5,6,7,8. `w_ready` drops the cycle after the 8th beat.
- npix=3, pixels 10,20,30 with `x_valid` always 1 → `pipe_en` pulses exactly every 4 cycles. `pe_en` is high for 12 consecutive cycles, `weight_sel` runs 0,1,2,3 repeating, and `prod_sel` lags it by 1. `prod_last` and `done` both assert exactly once, one cycle after the 12th `pe_en`.
- npix=2, with `x_valid` low for 5 cycles after the first pixel → `have` clears, `pe_en` gaps for 5 cycles, and 8 `prod_valid` cycles occur in total.
- npix=0 → no `pe_en`. `done` follows the last weight beat by 1 cycle.
- `start` pulsed during COMPUTE → ignored, and the job counts are unchanged.
- `rst_n` pulled low mid-LOAD (after beat 3) → all outputs read 0 and the state is IDLE. A new `start` restarts loading at PE0 slot 0.
